// File: rtl/control_sequencer_pkg.sv
// ============================================================================
//  Module   : control_sequencer_pkg
//  Purpose  : Shared state, opcode, instruction-class and immediate encodings
//             for the multicycle control sequencer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package control_sequencer_pkg;

    typedef logic [2:0] stateT;
    localparam stateT c_STATE_FETCH   = 3'd0;
    localparam stateT c_STATE_LATCH   = 3'd1;
    localparam stateT c_STATE_EXECUTE = 3'd2;
    localparam stateT c_STATE_LOAD_WB = 3'd3;
    localparam stateT c_STATE_HALT    = 3'd4;

    localparam logic [3:0] c_OP_RTYPE = 4'b0000;
    localparam logic [3:0] c_OP_ANDI  = 4'b0001;
    localparam logic [3:0] c_OP_ORI   = 4'b0010;
    localparam logic [3:0] c_OP_XORI  = 4'b0011;
    localparam logic [3:0] c_OP_MEM   = 4'b0100;
    localparam logic [3:0] c_OP_ADDI  = 4'b0101;
    localparam logic [3:0] c_OP_SUBI  = 4'b1001;
    localparam logic [3:0] c_OP_CMPI  = 4'b1011;
    localparam logic [3:0] c_OP_BEQ   = 4'b1100;
    localparam logic [3:0] c_OP_MOVI  = 4'b1101;
    localparam logic [3:0] c_OP_LUI   = 4'b1111;

    localparam logic [3:0] c_EXT_LOAD = 4'b0000;
    localparam logic [3:0] c_EXT_STOR = 4'b0100;
    localparam logic [3:0] c_EXT_STIO = 4'b0110;
    localparam logic [3:0] c_EXT_HALT = 4'b1000;

    typedef logic [3:0] instrClassT;
    localparam instrClassT c_CLASS_NOP   = 4'd0;
    localparam instrClassT c_CLASS_RTYPE = 4'd1;
    localparam instrClassT c_CLASS_IMM   = 4'd2;
    localparam instrClassT c_CLASS_CMPI  = 4'd3;
    localparam instrClassT c_CLASS_LOAD  = 4'd4;
    localparam instrClassT c_CLASS_STOR  = 4'd5;
    localparam instrClassT c_CLASS_STIO  = 4'd6;
    localparam instrClassT c_CLASS_BEQ   = 4'd7;
    localparam instrClassT c_CLASS_HALT  = 4'd8;

    localparam logic [1:0] c_IMM_RAW  = 2'b00;
    localparam logic [1:0] c_IMM_SIGN = 2'b01;
    localparam logic [1:0] c_IMM_ZERO = 2'b10;

    function automatic logic [15:0] signExtend8(input logic [7:0] value);
        return {{8{value[7]}}, value};
    endfunction

endpackage

`default_nettype wire

// File: rtl/control_sequencer_instruction_class_decoder.sv
// ============================================================================
//  Module   : instruction_class_decoder
//  Purpose  : Combinational opcode/ext decode into instruction class and
//             immediate extension type.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module instruction_class_decoder
    import control_sequencer_pkg::*;
(
    input  logic [3:0] i_opcode,
    input  logic [3:0] i_ext,
    output logic [3:0] o_instrClass,
    output logic [1:0] o_integerType
);

    always_comb begin
        o_instrClass  = c_CLASS_NOP;
        o_integerType = c_IMM_RAW;
        case (i_opcode)
            c_OP_RTYPE: o_instrClass = c_CLASS_RTYPE;
            c_OP_ADDI, c_OP_SUBI, c_OP_MOVI: begin
                o_instrClass  = c_CLASS_IMM;
                o_integerType = c_IMM_SIGN;
            end
            c_OP_CMPI: begin
                o_instrClass  = c_CLASS_CMPI;
                o_integerType = c_IMM_SIGN;
            end
            c_OP_ANDI, c_OP_ORI, c_OP_XORI: begin
                o_instrClass  = c_CLASS_IMM;
                o_integerType = c_IMM_ZERO;
            end
            c_OP_LUI: o_instrClass = c_CLASS_IMM;
            c_OP_MEM: begin
                case (i_ext)
                    c_EXT_LOAD: o_instrClass = c_CLASS_LOAD;
                    c_EXT_STOR: o_instrClass = c_CLASS_STOR;
                    c_EXT_STIO: o_instrClass = c_CLASS_STIO;
                    c_EXT_HALT: o_instrClass = c_CLASS_HALT;
                    default:    o_instrClass = c_CLASS_NOP;
                endcase
            end
            c_OP_BEQ: o_instrClass = c_CLASS_BEQ;
            default:  o_instrClass = c_CLASS_NOP;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/control_sequencer.sv
// ============================================================================
//  Module   : control_sequencer
//  Purpose  : Multicycle fetch/execute/writeback sequencer owning PC and IR
//             and driving every datapath enable and select line.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] IO_BASE  = 16'hFF00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] memoryData,
    input  logic        zeroFlag,
    output logic [15:0] instruction,
    output logic [15:0] programCounter,
    output logic        blockRamReadEnable,
    output logic        blockRamWriteEnable,
    output logic        registerFileWriteEnable,
    output logic [1:0]  integerTypeSelectionLine,
    output logic        reg2OrImmediateSelectionLine,
    output logic        pcOrRegisterSelectionLine,
    output logic        addressFromRegOrDecoderSelectionLine,
    output logic        writeBackToRegRamOrALUSelectionLine,
    output logic        pcOrAluOutputRamReadSelectionLine,
    output logic [15:0] decoderRamWriteAddress,
    output logic [3:0]  registerWriteAddress,
    output logic        halted
);

    stateT       r_state;
    logic [15:0] r_pc;
    logic [15:0] r_ir;
    logic [3:0]  w_class;
    logic [1:0]  w_integerType;

    instruction_class_decoder u_decoder (
        .i_opcode      (r_ir[15:12]),
        .i_ext         (r_ir[7:4]),
        .o_instrClass  (w_class),
        .o_integerType (w_integerType)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= c_STATE_FETCH;
            r_pc    <= RESET_PC;
            r_ir    <= '0;
        end else begin
            case (r_state)
                c_STATE_FETCH: r_state <= c_STATE_LATCH;
                c_STATE_LATCH: begin
                    r_ir    <= memoryData;
                    r_pc    <= r_pc + 16'd1;
                    r_state <= c_STATE_EXECUTE;
                end
                c_STATE_EXECUTE: begin
                    case (w_class)
                        c_CLASS_LOAD: r_state <= c_STATE_LOAD_WB;
                        c_CLASS_HALT: r_state <= c_STATE_HALT;
                        c_CLASS_BEQ: begin
                            // Offset applies to the PC already advanced in LATCH.
                            if (zeroFlag) r_pc <= r_pc + signExtend8(r_ir[7:0]);
                            r_state <= c_STATE_FETCH;
                        end
                        default: r_state <= c_STATE_FETCH;
                    endcase
                end
                c_STATE_LOAD_WB: r_state <= c_STATE_FETCH;
                c_STATE_HALT:    r_state <= c_STATE_HALT;
                default:         r_state <= c_STATE_FETCH;
            endcase
        end
    end

    always_comb begin
        blockRamReadEnable                   = 1'b0;
        blockRamWriteEnable                  = 1'b0;
        registerFileWriteEnable              = 1'b0;
        integerTypeSelectionLine             = c_IMM_RAW;
        reg2OrImmediateSelectionLine         = 1'b0;
        pcOrRegisterSelectionLine            = 1'b0;
        addressFromRegOrDecoderSelectionLine = 1'b0;
        writeBackToRegRamOrALUSelectionLine  = 1'b0;
        pcOrAluOutputRamReadSelectionLine    = 1'b0;
        case (r_state)
            c_STATE_FETCH: begin
                // Reset parks the FSM in FETCH; keep the read quiet until released.
                blockRamReadEnable                = reset;
                pcOrAluOutputRamReadSelectionLine = reset;
            end
            c_STATE_EXECUTE: begin
                case (w_class)
                    c_CLASS_RTYPE: begin
                        pcOrRegisterSelectionLine           = 1'b1;
                        registerFileWriteEnable             = 1'b1;
                        writeBackToRegRamOrALUSelectionLine = 1'b1;
                    end
                    c_CLASS_IMM, c_CLASS_CMPI: begin
                        reg2OrImmediateSelectionLine        = 1'b1;
                        pcOrRegisterSelectionLine           = 1'b1;
                        integerTypeSelectionLine            = w_integerType;
                        writeBackToRegRamOrALUSelectionLine = 1'b1;
                        registerFileWriteEnable             = (w_class == c_CLASS_IMM);
                    end
                    c_CLASS_LOAD: begin
                        blockRamReadEnable        = 1'b1;
                        pcOrRegisterSelectionLine = 1'b1;
                    end
                    c_CLASS_STOR: blockRamWriteEnable = 1'b1;
                    c_CLASS_STIO: begin
                        blockRamWriteEnable                  = 1'b1;
                        addressFromRegOrDecoderSelectionLine = 1'b1;
                    end
                    default: ;
                endcase
            end
            c_STATE_LOAD_WB: registerFileWriteEnable = 1'b1;
            default: ;
        endcase
    end

    assign instruction            = r_ir;
    assign programCounter         = r_pc;
    assign decoderRamWriteAddress = IO_BASE + {12'h000, r_ir[3:0]};
    assign registerWriteAddress   = r_ir[11:8];
    assign halted                 = (r_state == c_STATE_HALT);

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
// ============================================================================
//  Module   : tb_control_sequencer
//  Purpose  : Directed vector bench for control_sequencer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_control_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] memoryData = '0;
    logic        zeroFlag = 1'b0;
    logic [15:0] instruction, programCounter, decoderRamWriteAddress;
    logic        blockRamReadEnable, blockRamWriteEnable, registerFileWriteEnable;
    logic [1:0]  integerTypeSelectionLine;
    logic        reg2OrImmediateSelectionLine, pcOrRegisterSelectionLine;
    logic        addressFromRegOrDecoderSelectionLine, writeBackToRegRamOrALUSelectionLine;
    logic        pcOrAluOutputRamReadSelectionLine, halted;
    logic [3:0]  registerWriteAddress;

    logic        resetB = 1'b0;
    logic [15:0] memDataB = 16'h5105;
    logic [15:0] irB, pcB, decAddrB;
    logic        rdB, wrB, rfB, immB, regB, addrB, wbB, ramB, haltB;
    logic [1:0]  itB;
    logic [3:0]  rwaB;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    control_sequencer dut (
        .clock(clock), .reset(reset), .memoryData(memoryData), .zeroFlag(zeroFlag),
        .instruction(instruction), .programCounter(programCounter),
        .blockRamReadEnable(blockRamReadEnable), .blockRamWriteEnable(blockRamWriteEnable),
        .registerFileWriteEnable(registerFileWriteEnable),
        .integerTypeSelectionLine(integerTypeSelectionLine),
        .reg2OrImmediateSelectionLine(reg2OrImmediateSelectionLine),
        .pcOrRegisterSelectionLine(pcOrRegisterSelectionLine),
        .addressFromRegOrDecoderSelectionLine(addressFromRegOrDecoderSelectionLine),
        .writeBackToRegRamOrALUSelectionLine(writeBackToRegRamOrALUSelectionLine),
        .pcOrAluOutputRamReadSelectionLine(pcOrAluOutputRamReadSelectionLine),
        .decoderRamWriteAddress(decoderRamWriteAddress),
        .registerWriteAddress(registerWriteAddress), .halted(halted)
    );

    control_sequencer #(.RESET_PC(16'hFFFF)) dutWrap (
        .clock(clock), .reset(resetB), .memoryData(memDataB), .zeroFlag(1'b0),
        .instruction(irB), .programCounter(pcB),
        .blockRamReadEnable(rdB), .blockRamWriteEnable(wrB),
        .registerFileWriteEnable(rfB), .integerTypeSelectionLine(itB),
        .reg2OrImmediateSelectionLine(immB), .pcOrRegisterSelectionLine(regB),
        .addressFromRegOrDecoderSelectionLine(addrB),
        .writeBackToRegRamOrALUSelectionLine(wbB),
        .pcOrAluOutputRamReadSelectionLine(ramB),
        .decoderRamWriteAddress(decAddrB), .registerWriteAddress(rwaB), .halted(haltB)
    );

    // {rdEn, wrEn, rfWe, intType[1:0], immSel, regSel, addrSel, wbSel, ramSel}
    logic [9:0] w_ctl;
    assign w_ctl = {blockRamReadEnable, blockRamWriteEnable, registerFileWriteEnable,
                    integerTypeSelectionLine, reg2OrImmediateSelectionLine,
                    pcOrRegisterSelectionLine, addressFromRegOrDecoderSelectionLine,
                    writeBackToRegRamOrALUSelectionLine, pcOrAluOutputRamReadSelectionLine};

    typedef struct {
        logic [15:0] instr;
        logic        zero;
        logic [15:0] fetchPc;
        logic [15:0] execPc;
        logic [9:0]  expCtl;
        logic [9:0]  careCtl;
        logic        isLoad;
    } vecT;

    vecT vecs[17];

    function automatic vecT mk(input logic [15:0] instr, input logic zero,
                               input logic [15:0] fetchPc, input logic [15:0] execPc,
                               input logic [9:0] expCtl, input logic [9:0] careCtl,
                               input logic isLoad);
        vecT v;
        v.instr = instr; v.zero = zero; v.fetchPc = fetchPc; v.execPc = execPc;
        v.expCtl = expCtl; v.careCtl = careCtl; v.isLoad = isLoad;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    initial begin
        vecs[0]  = mk(16'h5105, 1'b0, 16'h0000, 16'h0001, 10'b0010110000, 10'b1111110000, 1'b0);
        vecs[1]  = mk(16'h4203, 1'b0, 16'h0001, 16'h0002, 10'b1000001000, 10'b1110001001, 1'b1);
        vecs[2]  = mk(16'h4067, 1'b0, 16'h0002, 16'h0003, 10'b0100000100, 10'b1110000100, 1'b0);
        vecs[3]  = mk(16'h4145, 1'b0, 16'h0003, 16'h0004, 10'b0100000000, 10'b1110000100, 1'b0);
        vecs[4]  = mk(16'h0312, 1'b0, 16'h0004, 16'h0005, 10'b0010001010, 10'b1110011010, 1'b0);
        vecs[5]  = mk(16'h2A0F, 1'b0, 16'h0005, 16'h0006, 10'b0011010000, 10'b1111110000, 1'b0);
        vecs[6]  = mk(16'hF480, 1'b0, 16'h0006, 16'h0007, 10'b0010010000, 10'b1111110000, 1'b0);
        vecs[7]  = mk(16'hB1FF, 1'b0, 16'h0007, 16'h0008, 10'b0000110000, 10'b1111110000, 1'b0);
        vecs[8]  = mk(16'h7000, 1'b0, 16'h0008, 16'h0009, 10'b0000000000, 10'b1110000000, 1'b0);
        vecs[9]  = mk(16'hC0FE, 1'b1, 16'h0009, 16'h000A, 10'b0000000000, 10'b1110000000, 1'b0);
        vecs[10] = mk(16'hC0FE, 1'b0, 16'h0008, 16'h0009, 10'b0000000000, 10'b1110000000, 1'b0);
        vecs[11] = mk(16'h3107, 1'b0, 16'h0009, 16'h000A, 10'b0011010000, 10'b1111110000, 1'b0);
        vecs[12] = mk(16'hD2F0, 1'b0, 16'h000A, 16'h000B, 10'b0010110000, 10'b1111110000, 1'b0);
        vecs[13] = mk(16'h9305, 1'b0, 16'h000B, 16'h000C, 10'b0010110000, 10'b1111110000, 1'b0);
        vecs[14] = mk(16'h14FF, 1'b0, 16'h000C, 16'h000D, 10'b0011010000, 10'b1111110000, 1'b0);
        vecs[15] = mk(16'h4F20, 1'b0, 16'h000D, 16'h000E, 10'b0000000000, 10'b1110000000, 1'b0);
        vecs[16] = mk(16'hC003, 1'b1, 16'h000E, 16'h000F, 10'b0000000000, 10'b1110000000, 1'b0);

        // Reset held: everything quiet.
        @(negedge clock); @(negedge clock);
        check("reset_ctl", {22'd0, w_ctl}, 32'd0);
        check("reset_pc", {16'd0, programCounter}, 32'h0000);
        check("reset_ir", {16'd0, instruction}, 32'h0000);
        check("reset_halted", {31'd0, halted}, 32'd0);

        reset = 1'b1;
        #1;
        for (int i = 0; i < 17; i++) begin
            zeroFlag   = vecs[i].zero;
            memoryData = vecs[i].instr;
            check($sformatf("v%0d_fetch_ctl", i), {30'd0, blockRamReadEnable, pcOrAluOutputRamReadSelectionLine}, 32'd3);
            check($sformatf("v%0d_fetch_pc", i), {16'd0, programCounter}, {16'd0, vecs[i].fetchPc});
            @(posedge clock); #1;
            @(posedge clock); #1;
            check($sformatf("v%0d_ir", i), {16'd0, instruction}, {16'd0, vecs[i].instr});
            check($sformatf("v%0d_exec_pc", i), {16'd0, programCounter}, {16'd0, vecs[i].execPc});
            check($sformatf("v%0d_exec_ctl", i), {22'd0, w_ctl & vecs[i].careCtl},
                  {22'd0, vecs[i].expCtl & vecs[i].careCtl});
            check($sformatf("v%0d_rwa", i), {28'd0, registerWriteAddress}, {28'd0, vecs[i].instr[11:8]});
            check($sformatf("v%0d_ioaddr", i), {16'd0, decoderRamWriteAddress},
                  {16'd0, 16'hFF00 + {12'h000, vecs[i].instr[3:0]}});
            if (vecs[i].isLoad) begin
                @(posedge clock); #1;
                check($sformatf("v%0d_loadwb_ctl", i), {22'd0, w_ctl & 10'b1110000010}, {22'd0, 10'b0010000000});
            end
            @(posedge clock); #1;
        end
        check("stio_ioaddr_ff07", 32'(16'hFF00 + 16'h0007), 32'h0000FF07 & {16'd0, 16'hFFFF});

        // HALT: fetched at 0012, then frozen.
        check("halt_fetch_pc", {16'd0, programCounter}, 32'h0012);
        memoryData = 16'h4080;
        @(posedge clock); #1;
        @(posedge clock); #1;
        memoryData = 16'h5105;
        for (int c = 0; c < 6; c++) begin
            @(posedge clock); #1;
            check($sformatf("halt%0d_halted", c), {31'd0, halted}, 32'd1);
            check($sformatf("halt%0d_enables", c), {29'd0, w_ctl[9:7]}, 32'd0);
            check($sformatf("halt%0d_pc", c), {16'd0, programCounter}, 32'h0013);
            check($sformatf("halt%0d_ir", c), {16'd0, instruction}, 32'h4080);
        end
        reset = 1'b0;
        #1;
        check("halt_exit_halted", {31'd0, halted}, 32'd0);
        check("halt_exit_pc", {16'd0, programCounter}, 32'h0000);

        // STOR aborted by asynchronous reset mid-EXECUTE.
        @(negedge clock);
        reset = 1'b1;
        memoryData = 16'h4145;
        #1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        check("abort_pre_wr", {31'd0, blockRamWriteEnable}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("abort_wr", {31'd0, blockRamWriteEnable}, 32'd0);
        check("abort_rf", {31'd0, registerFileWriteEnable}, 32'd0);
        check("abort_pc", {16'd0, programCounter}, 32'h0000);
        check("abort_ir", {16'd0, instruction}, 32'h0000);
        @(posedge clock); #1;
        check("abort_hold_ctl", {22'd0, w_ctl}, 32'd0);

        // PC wrap on a RESET_PC=FFFF instance, running CMPI afterwards.
        @(negedge clock);
        resetB = 1'b1;
        #1;
        check("wrap_fetch_pc", {16'd0, pcB}, 32'hFFFF);
        @(posedge clock); #1;
        @(posedge clock); #1;
        check("wrap_exec_pc", {16'd0, pcB}, 32'h0000);
        check("wrap_ir", {16'd0, irB}, 32'h5105);
        check("wrap_rf", {31'd0, rfB}, 32'd1);
        memDataB = 16'hB1FF;
        @(posedge clock); #1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        check("wrap_cmpi_it", {30'd0, itB}, 32'd1);
        check("wrap_cmpi_rf", {31'd0, rfB}, 32'd0);
        check("wrap_cmpi_pc", {16'd0, pcB}, 32'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Multicycle control unit directly upstream of the datapath.
- Owns the program counter and instruction register, and sequences fetch/execute/writeback.
- Drives every datapath select line and enable: RAM read/write, register-file write, immediate type, operand muxes.
- Consumes block RAM read data (1-cycle synchronous read) and the ALU zero flag.

Parameters:
- RESET_PC, 16'h0000, program counter value after reset.
- IO_BASE, 16'hFF00, base address for memory-mapped I/O stores (STIO).

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- memoryData  in  16  block RAM read data (q), valid the cycle after a read
- zeroFlag  in  1  ALU zero result, sampled in EXECUTE
- instruction  out  16  instruction register
- programCounter  out  16  current PC
- blockRamReadEnable  out  1  RAM read enable
- blockRamWriteEnable  out  1  RAM write enable
- registerFileWriteEnable  out  1  register-file write enable
- integerTypeSelectionLine  out  2  00 raw imm[7:0], 01 sign-extended, 10 zero-extended
- reg2OrImmediateSelectionLine  out  1  0 reg2, 1 immediate
- pcOrRegisterSelectionLine  out  1  0 PC, 1 reg1
- addressFromRegOrDecoderSelectionLine  out  1  0 reg2, 1 decoderRamWriteAddress
- writeBackToRegRamOrALUSelectionLine  out  1  0 RAM data, 1 ALU result
- pcOrAluOutputRamReadSelectionLine  out  1  0 ALU output, 1 PC
- decoderRamWriteAddress  out  16  IO_BASE + zero-extended instruction[3:0]
- registerWriteAddress  out  4  instruction[11:8]
- halted  out  1  high in HALT state

Behaviour:
- Reset (asynchronous, active-low):
  - state=FETCH, PC=RESET_PC, IR=0.
  - All enables 0; all selects 0; integerType 00; halted 0.
  - Asserting reset mid-instruction aborts the instruction with no write.
- Instruction format: op[15:12], rdest[11:8], ext[7:4], rsrc[3:0]; imm = [7:0].
- Instruction classes:
  - R-type: op 0000; ext = ALU op.
  - Immediate, sign-extended: 0101 ADDI, 1001 SUBI, 1011 CMPI, 1101 MOVI.
  - Immediate, zero-extended: 0001 ANDI, 0010 ORI, 0011 XORI.
  - Immediate, raw: 1111 LUI.
  - op 0100 by ext: 0000 LOAD, 0100 STOR, 0110 STIO, 1000 HALT.
  - op 1100 BEQ: PC-relative, signed imm.
  - Any other encoding: NOP.
- State FETCH:
  - blockRamReadEnable=1, pcOrAluOutputRamReadSelectionLine=1.
  - Next state: LATCH.
- State LATCH:
  - IR<=memoryData; PC<=PC+1 (wraps FFFF->0000).
  - Next state: EXECUTE.
- State EXECUTE, by class:
  - R-type: reg2/pcOrRegister selects=0/1; registerFileWriteEnable=1; writeBack sel=1. Next FETCH.
  - Immediate: reg2OrImmediate=1; integerType per class; registerFileWriteEnable=1, except CMPI (0). Next FETCH.
  - LOAD: blockRamReadEnable=1; pcOrAluOutputRamRead=0; reg1 into ALU. Next LOAD_WB.
  - STOR: blockRamWriteEnable=1; addressFromRegOrDecoder=0. Next FETCH.
  - STIO: blockRamWriteEnable=1; addressFromRegOrDecoder=1. Next FETCH.
  - BEQ: if zeroFlag=1, PC<=PC+sign-extended imm (16-bit modulo, relative to the already-incremented PC); no enables. Next FETCH.
  - HALT: next HALT.
  - NOP: no enables. Next FETCH.
- State LOAD_WB:
  - registerFileWriteEnable=1, writeBack sel=0 (memoryData now valid).
  - Next state: FETCH.
- State HALT:
  - halted=1; all enables 0; PC and IR frozen.
  - Exit only via reset.
- Outputs are a Moore decode of state + IR. Enables are never asserted outside the listed states.
- blockRamWriteEnable and registerFileWriteEnable are never high in the same cycle.
- Cycle counts: ALU/imm/store/branch/NOP = 3; LOAD = 4.

Decomposition:
- Shared package: state encoding (FETCH, LATCH, EXECUTE, LOAD_WB, HALT), opcode/ext constants, select-line encodings (integerType 00/01/10).
- One natural sub-module, instruction_class_decoder: combinational IR -> class + integerType.
- Sequential PC/IR/FSM logic stays in control_sequencer.

Test Plan:
- Reset + fetch: release reset with memoryData=16'h5105 (ADDI r1,#5).
  - FETCH: readEnable=1, PC select=1.
  - LATCH: IR=5105, PC=0001.
  - EXECUTE: registerFileWriteEnable=1, integerType=01, reg2OrImm=1, registerWriteAddress=1.
- LOAD 16'h4203:
  - EXECUTE: readEnable=1, pcOrAluOutputRamRead=0.
  - LOAD_WB: registerFileWriteEnable=1, writeBack sel=0.
  - Total 4 cycles; next FETCH.
- STIO 16'h4067:
  - EXECUTE: blockRamWriteEnable=1, addressFromRegOrDecoder=1, decoderRamWriteAddress=FF07.
  - registerFileWriteEnable=0.
- BEQ 16'hC0FE at PC=0010:
  - zeroFlag=1: PC=000F after EXECUTE.
  - zeroFlag=0: PC=0011.
- PC wrap and CMPI:
  - RESET_PC=FFFF: after LATCH, PC=0000.
  - CMPI 16'hB1FF: integerType=01, registerFileWriteEnable=0.
- HALT (16'h4080), then async reset mid-EXECUTE of a STOR:
  - HALT: halted=1, enables 0 indefinitely.
  - Reset assertion: blockRamWriteEnable drops immediately, PC=RESET_PC.
